// File: rtl/uart_rx_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg_ctrl_pkg
//  Purpose  : Shared types and constants for the UART receiver configuration
//             sequencer: FSM state encoding, legal prescale values, default
//             configuration and the configuration record.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_rx_cfg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    // Only these oversampling ratios are supported by the receiver.
    localparam logic [4:0] c_prescale_8  = 5'd8;
    localparam logic [4:0] c_prescale_16 = 5'd16;

    // Configuration driven out of reset.
    localparam int c_def_prescale = 8;
    localparam int c_def_par_en   = 0;
    localparam int c_def_par_typ  = 0;

    typedef struct packed {
        logic [4:0] prescale;
        logic       par_en;
        logic       par_typ;
    } cfg_t;

    function automatic logic prescale_is_valid(input logic [4:0] p);
        return (p == c_prescale_8) || (p == c_prescale_16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cfg_ctrl_line_idle_counter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg_ctrl_line_idle_counter
//  Purpose  : Counts consecutive clocks with the serial line high and flags a
//             quiet line once a full frame's worth of bit-times has elapsed.
//  Ports    : clk, rst_n      - clock, async active-low reset
//             rx_in           - serial line (synchronous to clk)
//             clear           - force the counter to zero (config applied)
//             prescale        - currently active oversampling ratio
//             quiet           - counter has reached IDLE_BITS*prescale
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg_ctrl_line_idle_counter #(
    parameter int IDLE_BITS = 11,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       clear,
    input  logic [4:0] prescale,
    output logic       quiet
);

    localparam logic [CNT_W-1:0] c_idle_bits = CNT_W'(IDLE_BITS);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_thresh;

    // Threshold follows the active prescale; CNT_W is sized so it never wraps.
    assign w_thresh = c_idle_bits * CNT_W'(prescale);
    assign quiet    = (r_cnt == w_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || !rx_in) begin
            r_cnt <= '0;
        end else if (r_cnt < w_thresh) begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg_ctrl
//  Purpose  : Configuration sequencer for the UART receiver. Accepts host
//             configuration writes at any time and commits them to the
//             receiver only at a safe point (quiet line, or byte delivered
//             with the line back at idle).
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             cfg_wr, cfg_prescale,
//             cfg_par_en, cfg_par_typ    - host write strobe and payload
//             rx_in                      - serial line (monitor only)
//             data_valid                 - byte-complete pulse from receiver
//             prescale, par_en, par_typ  - active configuration to receiver
//             cfg_busy                   - write pending, not yet committed
//             cfg_ack                    - pulse when new config goes active
//             cfg_err                    - pulse when a write is rejected
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg_ctrl
    import uart_rx_cfg_ctrl_pkg::*;
#(
    parameter int RST_PRESCALE = c_def_prescale,
    parameter int RST_PAR_EN   = c_def_par_en,
    parameter int RST_PAR_TYP  = c_def_par_typ,
    parameter int IDLE_BITS    = 11,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_wr,
    input  logic [4:0] cfg_prescale,
    input  logic       cfg_par_en,
    input  logic       cfg_par_typ,
    input  logic       rx_in,
    input  logic       data_valid,
    output logic [4:0] prescale,
    output logic       par_en,
    output logic       par_typ,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_err
);

    localparam cfg_t c_rst_cfg = '{
        prescale: 5'(RST_PRESCALE),
        par_en:   1'(RST_PAR_EN),
        par_typ:  1'(RST_PAR_TYP)
    };

    state_t r_state;
    cfg_t   r_cfg;
    cfg_t   r_shadow;
    logic   r_busy;
    logic   r_ack;
    logic   r_err;
    logic   r_hold;     // write arrived alongside a commit; resume PENDING

    logic   w_quiet;
    logic   w_wr_valid;
    logic   w_commit;
    logic   w_clear;
    cfg_t   w_wr_cfg;

    assign w_wr_cfg   = '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
    assign w_wr_valid = cfg_wr && prescale_is_valid(cfg_prescale);
    // A delivered byte only marks a safe point if the line is back at idle.
    assign w_commit   = (r_state == ST_PENDING) && (w_quiet || (data_valid && rx_in));
    // Restart idle detection so the threshold reflects the new prescale.
    assign w_clear    = (r_state == ST_APPLY);

    uart_rx_cfg_ctrl_line_idle_counter #(
        .IDLE_BITS (IDLE_BITS),
        .CNT_W     (CNT_W)
    ) u_idle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .clear    (w_clear),
        .prescale (r_cfg.prescale),
        .quiet    (w_quiet)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cfg    <= c_rst_cfg;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= cfg_wr && !prescale_is_valid(cfg_prescale);

            // Last valid write wins; a commit in the same cycle still sees
            // the old shadow value because of non-blocking update.
            if (w_wr_valid) begin
                r_shadow <= w_wr_cfg;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_valid) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_commit) begin
                        r_cfg   <= r_shadow;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_hold  <= w_wr_valid;
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_hold <= 1'b0;
                    if (w_wr_valid || r_hold) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_PENDING;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign prescale = r_cfg.prescale;
    assign par_en   = r_cfg.par_en;
    assign par_typ  = r_cfg.par_typ;
    assign cfg_busy = r_busy;
    assign cfg_ack  = r_ack;
    assign cfg_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg_ctrl
//  Purpose  : Directed self-checking bench for uart_rx_cfg_ctrl.
//             Observed vector = {prescale, par_en, par_typ, busy, ack, err}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_wr;
    logic [4:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       rx_in;
    logic       data_valid;
    logic [4:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       cfg_busy;
    logic       cfg_ack;
    logic       cfg_err;

    logic [9:0] obs;
    int         tests = 0;
    int         fails = 0;

    assign obs = {prescale, par_en, par_typ, cfg_busy, cfg_ack, cfg_err};

    always #5 clk = ~clk;

    uart_rx_cfg_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr       (cfg_wr),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .rx_in        (rx_in),
        .data_valid   (data_valid),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .cfg_busy     (cfg_busy),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] p, input logic e, input logic t);
        cfg_wr       = 1'b1;
        cfg_prescale = p;
        cfg_par_en   = e;
        cfg_par_typ  = t;
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        cfg_wr       = 1'b0;
        cfg_prescale = 5'd0;
        cfg_par_en   = 1'b0;
        cfg_par_typ  = 1'b0;
        data_valid   = 1'b0;
        rx_in        = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b000});
        end
        repeat (5) tick();
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL reset_idle_hold: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b000});
        end
    endtask

    task automatic test_quiet_commit;
        int first;
        do_reset();
        wr(5'd16, 1'b1, 1'b1);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b100}) begin
            fails++;
            $display("FAIL quiet_busy: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b100});
        end
        // Counter is 1 now; it reaches 88 after 87 more edges, ACK one later.
        first = -1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (cfg_ack) begin
                first = i;
                break;
            end
        end
        tests++;
        if (first != 88) begin
            fails++;
            $display("FAIL quiet_ack_latency: got %0d want %0d", first, 88);
        end
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b1, 3'b010}) begin
            fails++;
            $display("FAIL quiet_ack_outputs: got %h want %h", obs, {5'd16, 1'b1, 1'b1, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b1, 3'b000}) begin
            fails++;
            $display("FAIL quiet_after_ack: got %h want %h", obs, {5'd16, 1'b1, 1'b1, 3'b000});
        end
    endtask

    task automatic test_mid_frame;
        logic seen;
        do_reset();
        rx_in = 1'b0;
        wr(5'd16, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b0;
        // Frame-like activity: at most 5 consecutive high clocks.
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rx_in = ((i % 20) >= 15);
            tick();
            if (cfg_ack) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midframe_no_ack: got %b want %b", seen, 1'b0);
        end
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b100}) begin
            fails++;
            $display("FAIL midframe_hold: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b100});
        end
        rx_in      = 1'b0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick();
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b100}) begin
            fails++;
            $display("FAIL dv_rx_low_no_commit: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b100});
        end
        rx_in      = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        rx_in      = 1'b0;
        tests++;
        if (obs !== {5'd16, 1'b0, 1'b0, 3'b010}) begin
            fails++;
            $display("FAIL dv_commit: got %h want %h", obs, {5'd16, 1'b0, 1'b0, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL dv_after_ack: got %h want %h", obs, {5'd16, 1'b0, 1'b0, 3'b000});
        end
    endtask

    task automatic test_invalid;
        do_reset();
        rx_in = 1'b0;
        wr(5'd16, 1'b1, 1'b0);
        tick();
        wr(5'd12, 1'b0, 1'b1);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b101}) begin
            fails++;
            $display("FAIL invalid_err_pulse: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b101});
        end
        tick();
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b100}) begin
            fails++;
            $display("FAIL invalid_err_clear: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b100});
        end
        rx_in      = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        rx_in      = 1'b0;
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b0, 3'b010}) begin
            fails++;
            $display("FAIL invalid_shadow_kept: got %h want %h", obs, {5'd16, 1'b1, 1'b0, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL invalid_after_ack: got %h want %h", obs, {5'd16, 1'b1, 1'b0, 3'b000});
        end
        // Rejected write while idle: error pulse, no pending state.
        wr(5'd0, 1'b1, 1'b1);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b0, 3'b001}) begin
            fails++;
            $display("FAIL invalid_idle_err: got %h want %h", obs, {5'd16, 1'b1, 1'b0, 3'b001});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL invalid_idle_quiet: got %h want %h", obs, {5'd16, 1'b1, 1'b0, 3'b000});
        end
    endtask

    task automatic test_overwrite_collision;
        int first;
        do_reset();
        rx_in = 1'b0;
        wr(5'd16, 1'b1, 1'b0);
        tick();
        wr(5'd8, 1'b1, 1'b1);
        tick();
        cfg_wr     = 1'b0;
        rx_in      = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b1, 1'b1, 3'b010}) begin
            fails++;
            $display("FAIL overwrite_last_wins: got %h want %h", obs, {5'd8, 1'b1, 1'b1, 3'b010});
        end
        // Write in the ACK cycle becomes a new pending write.
        wr(5'd16, 1'b0, 1'b0);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b1, 1'b1, 3'b100}) begin
            fails++;
            $display("FAIL apply_write_busy: got %h want %h", obs, {5'd8, 1'b1, 1'b1, 3'b100});
        end
        // Counter cleared to 0 at this edge: 88 edges to quiet, ACK one later.
        first = -1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (cfg_ack) begin
                first = i;
                break;
            end
        end
        tests++;
        if (first != 89) begin
            fails++;
            $display("FAIL second_ack_latency: got %0d want %0d", first, 89);
        end
        tests++;
        if (obs !== {5'd16, 1'b0, 1'b0, 3'b010}) begin
            fails++;
            $display("FAIL second_ack_outputs: got %h want %h", obs, {5'd16, 1'b0, 1'b0, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL second_after_ack: got %h want %h", obs, {5'd16, 1'b0, 1'b0, 3'b000});
        end
    endtask

    task automatic test_back_to_back;
        rx_in = 1'b0;
        wr(5'd16, 1'b1, 1'b1);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd16, 1'b0, 1'b0, 3'b100}) begin
            fails++;
            $display("FAIL b2b_pending: got %h want %h", obs, {5'd16, 1'b0, 1'b0, 3'b100});
        end
        // Commit and a new write in the same cycle.
        rx_in      = 1'b1;
        data_valid = 1'b1;
        wr(5'd8, 1'b0, 1'b1);
        tick();
        cfg_wr     = 1'b0;
        data_valid = 1'b0;
        rx_in      = 1'b0;
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b1, 3'b010}) begin
            fails++;
            $display("FAIL b2b_commit_old: got %h want %h", obs, {5'd16, 1'b1, 1'b1, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd16, 1'b1, 1'b1, 3'b100}) begin
            fails++;
            $display("FAIL b2b_repending: got %h want %h", obs, {5'd16, 1'b1, 1'b1, 3'b100});
        end
        rx_in      = 1'b1;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        rx_in      = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b1, 3'b010}) begin
            fails++;
            $display("FAIL b2b_commit_new: got %h want %h", obs, {5'd8, 1'b0, 1'b1, 3'b010});
        end
        tick();
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b1, 3'b000}) begin
            fails++;
            $display("FAIL b2b_idle: got %h want %h", obs, {5'd8, 1'b0, 1'b1, 3'b000});
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        rx_in = 1'b0;
        wr(5'd16, 1'b1, 1'b0);
        tick();
        cfg_wr = 1'b0;
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b1, 3'b100}) begin
            fails++;
            $display("FAIL rstmid_pending: got %h want %h", obs, {5'd8, 1'b0, 1'b1, 3'b100});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL rstmid_async: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b000});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx_in = 1'b1;
        seen  = 1'b0;
        repeat (200) begin
            tick();
            if (cfg_ack) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_no_ack: got %b want %b", seen, 1'b0);
        end
        tests++;
        if (obs !== {5'd8, 1'b0, 1'b0, 3'b000}) begin
            fails++;
            $display("FAIL rstmid_final: got %h want %h", obs, {5'd8, 1'b0, 1'b0, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_quiet_commit();
        test_mid_frame();
        test_invalid();
        test_overwrite_collision();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg_ctrl.md
Name: uart_rx_cfg_ctrl

Overview:
Configuration sequencer for the UART receiver. It owns the PRESCALE/PAR_EN/PAR_TYP inputs of the receiver and accepts configuration writes from a host at any time. It commits a new configuration only at a safe point: the line has been quiet for a full frame, or the receiver has just delivered a byte with the line back at idle. This way the receiver never sees a configuration change mid-frame.

Parameters:
- RST_PRESCALE, 8: prescale value driven after reset.
- RST_PAR_EN, 0: parity enable driven after reset.
- RST_PAR_TYP, 0: parity type driven after reset (0 = even, 1 = odd).
- IDLE_BITS, 11: number of consecutive bit-times of RX_IN high that count as a quiet line. 11 covers start + 8 data + parity + stop.
- CNT_W, 10: idle counter width. Must satisfy 2^CNT_W > IDLE_BITS*31.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- CFG_WR  in  1  one-cycle configuration write strobe.
- CFG_PRESCALE  in  5  requested oversampling ratio.
- CFG_PAR_EN  in  1  requested parity enable.
- CFG_PAR_TYP  in  1  requested parity type.
- RX_IN  in  1  serial line, monitored only; already synchronous to CLK.
- DATA_VALID  in  1  byte-complete pulse from the receiver.
- PRESCALE  out  5  active prescale to the receiver.
- PAR_EN  out  1  active parity enable to the receiver.
- PAR_TYP  out  1  active parity type to the receiver.
- CFG_BUSY  out  1  high while a write is pending and not yet committed.
- CFG_ACK  out  1  one-cycle pulse in the cycle the new configuration becomes active on the outputs.
- CFG_ERR  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (RST low, asynchronous):
  - PRESCALE=RST_PRESCALE, PAR_EN=RST_PAR_EN, PAR_TYP=RST_PAR_TYP.
  - CFG_BUSY=0, CFG_ACK=0, CFG_ERR=0.
  - Shadow registers cleared, idle counter=0, state=IDLE.
  - Reset mid-pending discards the pending write; no ACK is issued.
- Write validation: CFG_PRESCALE must be 8 or 16.
  - Any other value: CFG_ERR=1 in the next cycle, write ignored, existing pending write and shadow registers untouched.
- Idle counter (runs in all states):
  - RX_IN=0: counter clears to 0.
  - RX_IN=1: counter increments, saturating at THRESH.
  - THRESH = IDLE_BITS*PRESCALE, using the currently active PRESCALE, computed at CNT_W bits.
  - quiet = (counter == THRESH).
- State machine:
  - IDLE:
    - Valid CFG_WR: latch the shadow registers, CFG_BUSY=1 from the next cycle, go to PENDING.
  - PENDING:
    - Valid CFG_WR: overwrite the shadow registers, stay in PENDING. The idle counter is not reset (last write wins).
    - Commit condition: quiet=1, or (DATA_VALID=1 and RX_IN=1). On commit, go to APPLY.
  - APPLY (one cycle):
    - Shadow values drive the outputs; CFG_ACK=1, CFG_BUSY=0.
    - Return to IDLE.
    - A valid CFG_WR in the APPLY cycle is latched as a new pending write: go to PENDING with CFG_BUSY=1 next cycle.
    - The idle counter is cleared in APPLY, so THRESH is re-evaluated against the new PRESCALE.
- Latency: from the commit condition true to the outputs updated with CFG_ACK high is exactly 1 cycle.
- Simultaneous events:
  - CFG_WR in the same cycle as a PENDING commit: the commit uses the shadow values from before the write. The new write stays pending (the state returns to PENDING after APPLY).
  - DATA_VALID with RX_IN=0 does not commit.
- Outputs never change outside APPLY or reset.

Decomposition:
- Shared package (uart_pkg): state encoding (IDLE/PENDING/APPLY), valid prescale constants (8, 16), default configuration constants.
- One natural sub-module: line_idle_counter (saturating counter, clear on RX_IN low, clear on apply, THRESH compare, quiet output).
- The FSM, shadow registers and validation stay in the top.

Test Plan:
- Reset then idle: RST low→high with RX_IN=1 → PRESCALE=8, PAR_EN=0, PAR_TYP=0, BUSY/ACK/ERR=0.
- Quiet-line commit: RX_IN high, write {16,1,1} → BUSY=1. ACK exactly when the counter reaches 88 clocks (11*8 with old prescale); outputs become {16,1,1} in the ACK cycle.
- Mid-frame hold: write {16,0,0} during a frame with PRESCALE=8 → no ACK before DATA_VALID. DATA_VALID with RX_IN=1 → ACK the next cycle, outputs {16,0,0}.
- Invalid write: CFG_PRESCALE=12 while a pending write is {16,1,0} → ERR pulse 1 cycle, BUSY stays 1, later ACK applies {16,1,0}.
- Overwrite and collision: write {16,1,0}, then {8,1,1} while pending → ACK applies {8,1,1}. A write {16,0,0} in the ACK cycle → BUSY=1 next cycle, second ACK after 88 more quiet clocks.
- Reset mid-pending: write pending, RST asserted → outputs back to defaults, no ACK after release.
